// File: rtl/vector_alu_mc_pkg.sv
// Shared definitions for the multi-cycle vector ALU: opcodes, FSM states,
// accumulator sizing and signed saturation helpers.
package valu_pkg;

  localparam logic [3:0] OP_VADD = 4'd0;
  localparam logic [3:0] OP_VDOT = 4'd1;
  localparam logic [3:0] OP_SMUL = 4'd2;
  localparam logic [3:0] OP_SST  = 4'd3;
  localparam logic [3:0] OP_VLD  = 4'd4;
  localparam logic [3:0] OP_VST  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SLH  = 4'd7;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Dot-product accumulator width: full product plus one bit per lane doubling.
  function automatic int acc_width(input int lanes, input int lane_w);
    return 2 * lane_w + $clog2(lanes);
  endfunction

  // Largest signed value representable in w bits.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Clamp a signed value into the w-bit signed range.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = sat_max(w);
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/vector_alu_mc_if.sv
// Request/response bundle between the execute stage and the vector ALU.
interface vector_alu_mc_if #(
  parameter int LANES  = 16,
  parameter int LANE_W = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                opcode;
  logic [LANES*LANE_W-1:0]   op_1;
  logic [LANES*LANE_W-1:0]   op_2;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*LANE_W-1:0]   result;
  logic                      out_err;

  modport master (
    output in_valid, opcode, op_1, op_2, out_ready,
    input  in_ready, out_valid, result, out_err
  );

  modport slave (
    input  in_valid, opcode, op_1, op_2, out_ready,
    output in_ready, out_valid, result, out_err
  );
endinterface

// File: rtl/vector_alu_mc_lane_mac_group.sv
// MAC_PER_CYC signed lane multipliers with per-lane products and their sum;
// shared by the dot-product and scalar-multiply paths.
module lane_mac_group #(
  parameter int MAC_PER_CYC = 1,
  parameter int LANE_W      = 16,
  parameter int SUM_W       = 2 * LANE_W + $clog2(MAC_PER_CYC)
) (
  input  logic [MAC_PER_CYC*LANE_W-1:0]    a,
  input  logic [MAC_PER_CYC*LANE_W-1:0]    b,
  output logic [MAC_PER_CYC*2*LANE_W-1:0]  prod,
  output logic signed [SUM_W-1:0]          sum
);

  logic signed [2*LANE_W-1:0] p;

  // Multiply each lane pair and reduce the products into one signed sum.
  always_comb begin
    p    = '0;
    prod = '0;
    sum  = '0;
    for (int i = 0; i < MAC_PER_CYC; i++) begin
      p = $signed(a[i*LANE_W +: LANE_W]) * $signed(b[i*LANE_W +: LANE_W]);
      prod[i*2*LANE_W +: 2*LANE_W] = p;
      sum = sum + SUM_W'(p);
    end
  end

endmodule

// File: rtl/vector_alu_mc.sv
// Multi-cycle vector ALU: single-cycle lane ops plus lane-serial VDOT/SMUL,
// valid/ready on both sides, all outputs registered.
module vector_alu_mc
  import valu_pkg::*;
#(
  parameter int LANES       = 16,
  parameter int LANE_W      = 16,
  parameter int MAC_PER_CYC = 1,
  parameter int SAT         = 0
) (
  input  logic           clk,
  input  logic           rst,
  vector_alu_mc_if.slave bus
);

  localparam int G     = LANES / MAC_PER_CYC;
  localparam int ACC_W = acc_width(LANES, LANE_W);
  localparam int RES_W = LANES * LANE_W;
  localparam int GRP_W = MAC_PER_CYC * LANE_W;
  localparam int SUM_W = 2 * LANE_W + $clog2(MAC_PER_CYC);
  localparam int CNT_W = (G > 1) ? $clog2(G) : 1;
  localparam int HALF  = LANE_W / 2;

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [3:0]                 op_q;
  logic [RES_W-1:0]           op1_q;
  logic [RES_W-1:0]           op2_q;
  logic [RES_W-1:0]           vec_q;
  logic [RES_W-1:0]           result_q;
  logic signed [ACC_W-1:0]    acc;
  logic                       err_q;
  logic                       in_ready_q;
  logic                       out_valid_q;

  logic [GRP_W-1:0]             mac_a;
  logic [GRP_W-1:0]             mac_b;
  logic [MAC_PER_CYC*2*LANE_W-1:0] mac_prod;
  logic signed [SUM_W-1:0]      mac_sum;
  logic signed [ACC_W-1:0]      acc_next;
  logic [RES_W-1:0]             vec_next;
  logic [RES_W-1:0]             imm_res;
  logic                         imm_err;

  // Lane add with wrap or saturation.
  function automatic logic [LANE_W-1:0] add_lane(input logic [LANE_W-1:0] x,
                                                 input logic [LANE_W-1:0] y);
    logic signed [LANE_W:0] s;
    s = $signed({x[LANE_W-1], x}) + $signed({y[LANE_W-1], y});
    if (SAT != 0) return LANE_W'(sat_s(64'(s), LANE_W));
    return s[LANE_W-1:0];
  endfunction

  // Narrow a full-width lane product to LANE_W by truncation or saturation.
  function automatic logic [LANE_W-1:0] mul_lane(input logic signed [2*LANE_W-1:0] p);
    if (SAT != 0) return LANE_W'(sat_s(64'(p), LANE_W));
    return p[LANE_W-1:0];
  endfunction

  // Current lane group feeds the shared multipliers; SMUL broadcasts scalar lane 0.
  assign mac_a = op1_q[int'(cnt)*GRP_W +: GRP_W];
  assign mac_b = (op_q == OP_SMUL) ? {MAC_PER_CYC{op2_q[LANE_W-1:0]}}
                                   : op2_q[int'(cnt)*GRP_W +: GRP_W];

  lane_mac_group #(
    .MAC_PER_CYC(MAC_PER_CYC),
    .LANE_W     (LANE_W),
    .SUM_W      (SUM_W)
  ) u_mac (
    .a   (mac_a),
    .b   (mac_b),
    .prod(mac_prod),
    .sum (mac_sum)
  );

  assign acc_next = acc + ACC_W'(mac_sum);

  // Merge this cycle's SMUL lanes into the working vector.
  always_comb begin
    vec_next = vec_q;
    for (int j = 0; j < MAC_PER_CYC; j++) begin
      vec_next[(int'(cnt)*MAC_PER_CYC + j)*LANE_W +: LANE_W] =
        mul_lane($signed(mac_prod[j*2*LANE_W +: 2*LANE_W]));
    end
  end

  // Single-cycle results computed from the offered request.
  always_comb begin
    imm_res = '0;
    imm_err = 1'b0;
    case (bus.opcode)
      OP_VADD: begin
        for (int i = 0; i < LANES; i++) begin
          imm_res[i*LANE_W +: LANE_W] = add_lane(bus.op_1[i*LANE_W +: LANE_W],
                                                 bus.op_2[i*LANE_W +: LANE_W]);
        end
      end
      OP_SST, OP_VLD, OP_VST, OP_J:
        imm_res[LANE_W-1:0] = bus.op_1[LANE_W-1:0] + bus.op_2[LANE_W-1:0];
      OP_SLL:
        imm_res[LANE_W-1:0] = {bus.op_1[LANE_W-1:HALF], bus.op_2[HALF-1:0]};
      OP_SLH:
        imm_res[LANE_W-1:0] = {bus.op_2[HALF-1:0], bus.op_1[HALF-1:0]};
      OP_NOP, OP_VDOT, OP_SMUL: imm_res = '0;
      default: imm_err = 1'b1;
    endcase
  end

  // Control FSM: accept in IDLE, iterate lane groups in RUN, present result in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.opcode;
            op1_q      <= bus.op_1;
            op2_q      <= bus.op_2;
            in_ready_q <= 1'b0;
            if (bus.opcode == OP_VDOT || bus.opcode == OP_SMUL) begin
              cnt   <= '0;
              acc   <= '0;
              state <= RUN;
            end else begin
              result_q    <= imm_res;
              err_q       <= imm_err;
              out_valid_q <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          acc   <= acc_next;
          vec_q <= vec_next;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(G - 1)) begin
            result_q    <= (op_q == OP_VDOT) ? RES_W'(acc_next) : vec_next;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            cnt         <= '0;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_err   = err_q;

endmodule
